distortion_sequencer: RTL and testbench



---
 rtl/distortion_pkg.sv | 13 +
 rtl/gain_ramp.sv | 42 ++++
 rtl/distortion_sequencer.sv | 136 +++++++++++++
 tb/tb_distortion_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/distortion_pkg.sv
// Shared types and constants for the distortion sequencer and its gain ramp.
package distortion_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_RUN   = 2'd1,
    SEQ_DRAIN = 2'd2
  } seq_state_t;

  localparam logic [23:0] GAIN_UNITY = 24'h100000;
  localparam logic [23:0] THRESH_MAX = 24'h7FFFFF;

endpackage

// File: rtl/gain_ramp.sv
// Gain target latch plus a slew limiter that steps the live gain toward the
// target by at most RAMP_STEP per advance strobe.
module gain_ramp
  import distortion_pkg::*;
#(
  parameter int unsigned      WIDTH      = 24,
  parameter logic [WIDTH-1:0] RAMP_STEP  = WIDTH'(24'h000400),
  parameter logic [WIDTH-1:0] GAIN_RESET = WIDTH'(GAIN_UNITY)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] gain_target,
  input  logic             advance,
  output logic [WIDTH-1:0] gain_cur
);

  logic [WIDTH-1:0] gain_tgt;
  logic [WIDTH-1:0] tgt_eff;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] step;
  logic             up;

  // A load in the same cycle as an advance already steers that step.
  always_comb begin
    tgt_eff = cfg_load ? gain_target : gain_tgt;
    up      = tgt_eff > gain_cur;
    diff    = up ? (tgt_eff - gain_cur) : (gain_cur - tgt_eff);
    step    = (diff > RAMP_STEP) ? RAMP_STEP : diff;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gain_tgt <= GAIN_RESET;
      gain_cur <= GAIN_RESET;
    end else begin
      if (cfg_load) gain_tgt <= gain_target;
      if (advance)  gain_cur <= up ? (gain_cur + step) : (gain_cur - step);
    end
  end

endmodule

// File: rtl/distortion_sequencer.sv
// Valid/ready flow controller for the enable-gated distortion datapath:
// issues datapath advances, tracks real samples in flight and drains with bubbles.
module distortion_sequencer
  import distortion_pkg::*;
#(
  parameter int unsigned      WIDTH       = 24,
  parameter int unsigned      LATENCY     = 4,
  parameter logic [WIDTH-1:0] RAMP_STEP   = WIDTH'(24'h000400),
  parameter int unsigned      IDLE_CYCLES = 1024,
  parameter logic [WIDTH-1:0] GAIN_RESET  = WIDTH'(GAIN_UNITY)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] gain_target,
  input  logic [WIDTH-1:0] threshold_cfg,
  input  logic             flush,
  output logic             busy,
  output logic             dp_enable,
  output logic [WIDTH-1:0] dp_in,
  output logic [WIDTH-1:0] dp_gain,
  output logic [WIDTH-1:0] dp_threshold,
  input  logic [WIDTH-1:0] dp_out
);

  localparam int unsigned      CNT_W      = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] THRESH_RST = {1'b0, {(WIDTH-1){1'b1}}};

  seq_state_t         state;
  seq_state_t         state_nxt;
  logic [LATENCY-1:0] vld_pipe;
  logic [CNT_W-1:0]   idle_cnt;
  logic               can_adv;
  logic               accept;
  logic               inner_busy;

  assign out_valid  = vld_pipe[LATENCY-1];
  assign out_data   = dp_out;
  assign can_adv    = !out_valid || out_ready;
  assign inner_busy = |vld_pipe[LATENCY-2:0];
  assign busy       = (|vld_pipe) || (state != SEQ_IDLE);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SEQ_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      SEQ_IDLE: begin
        if (accept) state_nxt = SEQ_RUN;
      end
      SEQ_RUN: begin
        if (flush)                                     state_nxt = SEQ_DRAIN;
        else if (accept)                               state_nxt = SEQ_RUN;
        else if (vld_pipe == '0)                       state_nxt = SEQ_IDLE;
        else if (idle_cnt == CNT_LAST)                 state_nxt = SEQ_DRAIN;
      end
      SEQ_DRAIN: begin
        if (!inner_busy) state_nxt = SEQ_IDLE;
      end
      default: state_nxt = SEQ_IDLE;
    endcase
  end

  // Handshake and datapath strobes; flush only takes effect from RUN
  always_comb begin
    in_ready  = 1'b0;
    accept    = 1'b0;
    dp_enable = 1'b0;
    dp_in     = '0;
    case (state)
      SEQ_IDLE: in_ready = can_adv;
      SEQ_RUN:  in_ready = can_adv && !flush;
      SEQ_DRAIN: begin
        if (inner_busy) dp_enable = can_adv;
      end
      default: in_ready = 1'b0;
    endcase
    accept = in_valid && in_ready;
    if (accept) begin
      dp_enable = 1'b1;
      dp_in     = in_data;
    end
  end

  // Slot occupancy: shift on every advance, retire the head on a bare handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
    end else if (dp_enable) begin
      vld_pipe <= {vld_pipe[LATENCY-2:0], accept};
    end else if (out_valid && out_ready) begin
      vld_pipe[LATENCY-1] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
    end else if ((state == SEQ_RUN) && (state_nxt == SEQ_RUN) && !accept) begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end else begin
      idle_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        dp_threshold <= THRESH_RST;
    else if (cfg_load) dp_threshold <= threshold_cfg;
  end

  gain_ramp #(
    .WIDTH      (WIDTH),
    .RAMP_STEP  (RAMP_STEP),
    .GAIN_RESET (GAIN_RESET)
  ) u_gain_ramp (
    .clk         (clk),
    .reset       (reset),
    .cfg_load    (cfg_load),
    .gain_target (gain_target),
    .advance     (accept),
    .gain_cur    (dp_gain)
  );

endmodule

// File: tb/tb_distortion_sequencer.sv
// Directed bench for distortion_sequencer with a behavioural 4-stage datapath.
module tb_distortion_sequencer;
  import distortion_pkg::*;

  localparam int unsigned W = 24;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
  logic         cfg_load, flush, busy, dp_enable;
  logic [W-1:0] gain_target, threshold_cfg;
  logic [W-1:0] dp_in, dp_gain, dp_threshold;
  logic [W-1:0] dp_out = '0;
  logic [W-1:0] p0 = '0, p1 = '0, p2 = '0;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int en_cnt = 0;
  int ov_cnt = 0;
  int stall_cnt = 0;
  logic [W-1:0] outq[$];

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] dexp;
  } vec_t;

  typedef struct {
    logic         load;
    logic [W-1:0] tgt;
    int           nsamp;
    logic [W-1:0] exp_gain;
  } ramp_t;

  vec_t  stream_tbl[16];
  ramp_t ramp_tbl[9];

  always #5 clk = ~clk;

  distortion_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .cfg_load      (cfg_load),
    .gain_target   (gain_target),
    .threshold_cfg (threshold_cfg),
    .flush         (flush),
    .busy          (busy),
    .dp_enable     (dp_enable),
    .dp_in         (dp_in),
    .dp_gain       (dp_gain),
    .dp_threshold  (dp_threshold),
    .dp_out        (dp_out)
  );

  // Gain (4.20) -> rectify -> clip, applied at capture then delayed 3 more advances
  function automatic logic [W-1:0] dp_func(input logic [W-1:0] x, input logic [W-1:0] g,
                                           input logic [W-1:0] t);
    logic signed [49:0] p;
    logic signed [49:0] a;
    p = $signed({{(50-W){x[W-1]}}, x}) * $signed({{(50-W){1'b0}}, g});
    p = p >>> 20;
    a = (p < 0) ? -p : p;
    if (a > $signed({{(50-W){1'b0}}, t})) return t;
    return a[W-1:0];
  endfunction

  always @(posedge clk) begin
    if (dp_enable) begin
      p0     <= dp_func(dp_in, dp_gain, dp_threshold);
      p1     <= p0;
      p2     <= p1;
      dp_out <= p2;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (out_valid && out_ready) outq.push_back(out_data);
      if (in_valid && in_ready)   acc_cnt++;
      if (in_valid && !in_ready)  stall_cnt++;
      if (dp_enable)              en_cnt++;
      if (out_valid)              ov_cnt++;
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] d);
    logic ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("send_accept", W'(ok), W'(1'b1));
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic load_cfg(input logic [W-1:0] g, input logic [W-1:0] t);
    cfg_load      = 1'b1;
    gain_target   = g;
    threshold_cfg = t;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (!busy) break;
    end
    check(name, W'(busy), W'(1'b0));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int acc_snap;
    logic [W-1:0] exp_sq[3];

    stream_tbl[0]  = '{24'h000001, 24'h000001};
    stream_tbl[1]  = '{24'h000010, 24'h000010};
    stream_tbl[2]  = '{24'hFFFE00, 24'h000200};
    stream_tbl[3]  = '{24'h123456, 24'h123456};
    stream_tbl[4]  = '{24'h7FFFFF, 24'h7FFFFF};
    stream_tbl[5]  = '{24'h800001, 24'h7FFFFF};
    stream_tbl[6]  = '{24'h000000, 24'h000000};
    stream_tbl[7]  = '{24'h3FFFFF, 24'h3FFFFF};
    stream_tbl[8]  = '{24'hC00000, 24'h400000};
    stream_tbl[9]  = '{24'h0ABCDE, 24'h0ABCDE};
    stream_tbl[10] = '{24'hFFFFFF, 24'h000001};
    stream_tbl[11] = '{24'h000055, 24'h000055};
    stream_tbl[12] = '{24'h555555, 24'h555555};
    stream_tbl[13] = '{24'hAAAAAA, 24'h555556};
    stream_tbl[14] = '{24'h010203, 24'h010203};
    stream_tbl[15] = '{24'h0F0F0F, 24'h0F0F0F};

    ramp_tbl[0] = '{1'b1, 24'h101000, 3, 24'h100C00};
    ramp_tbl[1] = '{1'b0, 24'h000000, 1, 24'h101000};
    ramp_tbl[2] = '{1'b0, 24'h000000, 2, 24'h101000};
    ramp_tbl[3] = '{1'b1, 24'h100000, 1, 24'h100C00};
    ramp_tbl[4] = '{1'b1, 24'h0FF000, 1, 24'h100800};
    ramp_tbl[5] = '{1'b0, 24'h000000, 5, 24'h0FF400};
    ramp_tbl[6] = '{1'b0, 24'h000000, 1, 24'h0FF000};
    ramp_tbl[7] = '{1'b0, 24'h000000, 2, 24'h0FF000};
    ramp_tbl[8] = '{1'b1, 24'h0FF100, 1, 24'h0FF100};

    reset         = 1'b0;
    in_valid      = 1'b0;
    in_data       = '0;
    out_ready     = 1'b1;
    cfg_load      = 1'b0;
    gain_target   = GAIN_UNITY;
    threshold_cfg = THRESH_MAX;
    flush         = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", W'(out_valid), W'(1'b0));
    check("rst_busy", W'(busy), W'(1'b0));
    check("rst_dp_enable", W'(dp_enable), W'(1'b0));
    check("rst_dp_gain", dp_gain, GAIN_UNITY);
    check("rst_dp_threshold", dp_threshold, THRESH_MAX);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single sample, drained only by the idle timeout
    en_cnt = 0;
    outq.delete();
    send(24'h000100);
    cyc = 0;
    for (int i = 0; i < 1100; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      if (out_valid) break;
    end
    check("t1_timeout_latency", W'(cyc), W'(1027));
    check("t1_enables", W'(en_cnt), W'(4));
    check("t1_out_data", out_data, 24'h000100);
    wait_idle("t1_idle");
    check("t1_out_count", W'(outq.size()), W'(1));
    if (outq.size() > 0) check("t1_out_value", outq[0], 24'h000100);

    // Back-to-back stream
    outq.delete();
    stall_cnt = 0;
    acc_cnt   = 0;
    foreach (stream_tbl[i]) send(stream_tbl[i].din);
    check("t2_in_ready_held", W'(stall_cnt), W'(0));
    check("t2_accepts", W'(acc_cnt), W'(16));
    pulse_flush();
    wait_idle("t2_idle");
    check("t2_out_count", W'(outq.size()), W'(16));
    foreach (stream_tbl[i]) begin
      if (i < outq.size()) check($sformatf("t2_out_%0d", i), outq[i], stream_tbl[i].dexp);
    end

    // Downstream stall with a full pipe
    outq.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(stream_tbl[i].din);
    in_valid = 1'b1;
    in_data  = stream_tbl[4].din;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_stall_ctl", W'({dp_enable, in_ready, out_valid}), W'(3'b001));
      check("t3_stall_data", out_data, stream_tbl[0].dexp);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 4; i < 8; i++) send(stream_tbl[i].din);
    pulse_flush();
    wait_idle("t3_idle");
    check("t3_out_count", W'(outq.size()), W'(8));
    for (int i = 0; i < 8; i++) begin
      if (i < outq.size()) check($sformatf("t3_out_%0d", i), outq[i], stream_tbl[i].dexp);
    end

    // Gain ramp, retarget and partial final step
    foreach (ramp_tbl[i]) begin
      if (ramp_tbl[i].load) begin
        load_cfg(ramp_tbl[i].tgt, THRESH_MAX);
        if (i == 0) check("t4_load_no_step", dp_gain, GAIN_UNITY);
      end
      for (int k = 0; k < ramp_tbl[i].nsamp; k++) send(24'h000010);
      check($sformatf("t4_gain_%0d", i), dp_gain, ramp_tbl[i].exp_gain);
    end
    pulse_flush();
    wait_idle("t4_idle");

    // Threshold lands next cycle and clips the following sample
    outq.delete();
    cfg_load      = 1'b1;
    gain_target   = 24'h0FF100;
    threshold_cfg = 24'h000300;
    @(negedge clk);
    check("t4_thr_before", dp_threshold, THRESH_MAX);
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    check("t4_thr_after", dp_threshold, 24'h000300);
    send(24'h000500);
    pulse_flush();
    wait_idle("t4_thr_idle");
    check("t4_thr_count", W'(outq.size()), W'(1));
    if (outq.size() > 0) check("t4_thr_clip", outq[0], 24'h000300);

    // Flush with in_valid held high
    do_reset();
    outq.delete();
    out_ready = 1'b0;
    exp_sq    = '{24'h000011, 24'h000022, 24'h000033};
    for (int i = 0; i < 3; i++) send(exp_sq[i]);
    acc_snap = acc_cnt;
    in_valid = 1'b1;
    in_data  = 24'h000777;
    flush    = 1'b1;
    @(negedge clk);
    check("t5_flush_wins", W'(in_ready), W'(1'b0));
    @(posedge clk);
    #1;
    flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_drain_ctl", W'({in_ready, busy}), W'(2'b01));
    end
    check("t5_no_accept", W'(acc_cnt - acc_snap), W'(0));
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (!busy) break;
    end
    check("t5_busy_drop", W'(busy), W'(1'b0));
    check("t5_out_count", W'(outq.size()), W'(3));
    check("t5_back_idle", W'(in_ready), W'(1'b1));
    for (int i = 0; i < 3; i++) begin
      if (i < outq.size()) check($sformatf("t5_out_%0d", i), outq[i], exp_sq[i]);
    end

    // Reset with two samples in flight
    load_cfg(24'h200000, THRESH_MAX);
    send(24'h000010);
    send(24'h000020);
    check("t6_gain_pre", dp_gain, 24'h100800);
    #1 reset = 1'b0;
    #1;
    check("t6_out_valid", W'(out_valid), W'(1'b0));
    check("t6_busy", W'(busy), W'(1'b0));
    check("t6_gain", dp_gain, GAIN_UNITY);
    check("t6_thr", dp_threshold, THRESH_MAX);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    outq.delete();
    ov_cnt = 0;
    repeat (40) @(posedge clk);
    #1;
    check("t6_no_spurious", W'(ov_cnt), W'(0));
    check("t6_busy_after", W'(busy), W'(1'b0));
    send(24'h000010);
    check("t6_target_reset", dp_gain, GAIN_UNITY);
    pulse_flush();
    wait_idle("t6_idle");
    check("t6_out_count", W'(outq.size()), W'(1));
    if (outq.size() > 0) check("t6_out_value", outq[0], 24'h000010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
